// File: rtl/uart_rx_param.sv
// Runtime-configurable UART receiver, break detection under UART_RX_BREAK_DET_EN.
// Latency: m_valid_o rises one clk after WEND (mid final stop bit).
// Backpressure: one-word holding register; a frame arriving while it is full is dropped with overrun_o.
module uart_rx_param #(
  parameter int DATA_W = 8,
  parameter int RATIO  = 8,
  parameter int DIV_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_i,
  input  logic [DIV_W-1:0]  baud_div_i,
  input  logic [3:0]        data_bits_i,
  input  logic [1:0]        parity_mode_i,
  input  logic              stop2_i,
  output logic [DATA_W-1:0] m_data_o,
  output logic              m_valid_o,
  input  logic              m_ready_i,
  output logic              parity_err_o,
  output logic              frame_err_o,
  output logic              overrun_o,
  output logic              busy_o,
  output logic              break_o
);

  localparam int TW = $clog2(RATIO);
  localparam logic [TW-1:0] T_S0   = TW'(RATIO/2 - 1);
  localparam logic [TW-1:0] T_S1   = TW'(RATIO/2);
  localparam logic [TW-1:0] T_VOTE = TW'(RATIO/2 + 1);
  localparam logic [TW-1:0] T_LAST = TW'(RATIO - 1);

  typedef enum logic [2:0] {IDLE, RSTRB, RDT, RPARB, RSTB1, RSTB2, WEND} state_t;

  state_t            state, state_nxt;
  logic              rx_meta, rxs, rxs_d;
  logic [DIV_W-1:0]  presc;
  logic [TW-1:0]     tcnt;
  logic              tick, vote_tick, end_tick, start;
  logic              s0, s1, vote;
  logic [4:0]        nbits, nbits_clamp, bit_cnt;
  logic [1:0]        pmode;
  logic              pen, stop2_l;
  logic [DATA_W-1:0] shreg;
  logic              perr, ferr, wend_wr;
`ifdef UART_RX_BREAK_DET_EN
  logic              allz, brk;
`endif

  assign tick      = (presc == '0);
  assign vote_tick = tick && (tcnt == T_VOTE);
  assign end_tick  = tick && (tcnt == T_LAST);
  assign vote      = (s0 & s1) | (s0 & rxs) | (s1 & rxs);
  assign start     = (state == IDLE) && rxs_d && !rxs;
  assign pen       = (pmode == 2'b01) || (pmode == 2'b10);
  assign busy_o    = (state != IDLE);

  always_comb begin
    nbits_clamp = {1'b0, data_bits_i};
    if (data_bits_i < 4'd5)
      nbits_clamp = 5'd5;
    else if ({1'b0, data_bits_i} > 5'(DATA_W))
      nbits_clamp = 5'(DATA_W);
  end

`ifdef UART_RX_BREAK_DET_EN
  assign wend_wr = (state == WEND) && !brk;
`else
  assign wend_wr = (state == WEND);
  assign break_o = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (start) state_nxt = RSTRB;
      RSTRB: begin
        if (vote_tick && vote) state_nxt = IDLE;
        else if (end_tick)     state_nxt = RDT;
      end
      RDT:   if (end_tick && (bit_cnt == nbits)) state_nxt = pen ? RPARB : RSTB1;
      RPARB: if (end_tick) state_nxt = RSTB1;
      // Stop bits hand over at mid-bit so back-to-back frames can resync.
      RSTB1: begin
        if (vote_tick) begin
          state_nxt = stop2_l ? RSTB2 : WEND;
`ifdef UART_RX_BREAK_DET_EN
          if (allz && !vote) state_nxt = WEND;
`endif
        end
      end
      RSTB2: if (vote_tick) state_nxt = WEND;
      WEND: begin
`ifdef UART_RX_BREAK_DET_EN
        if (!brk || rxs) state_nxt = IDLE;
`else
        state_nxt = IDLE;
`endif
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta      <= 1'b1;
      rxs          <= 1'b1;
      rxs_d        <= 1'b1;
      presc        <= '0;
      tcnt         <= '0;
      s0           <= 1'b0;
      s1           <= 1'b0;
      nbits        <= 5'd5;
      pmode        <= 2'b00;
      stop2_l      <= 1'b0;
      bit_cnt      <= '0;
      shreg        <= '0;
      perr         <= 1'b0;
      ferr         <= 1'b0;
      m_data_o     <= '0;
      m_valid_o    <= 1'b0;
      parity_err_o <= 1'b0;
      frame_err_o  <= 1'b0;
      overrun_o    <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
      allz         <= 1'b1;
      brk          <= 1'b0;
      break_o      <= 1'b0;
`endif
    end else begin
      rx_meta   <= rx_i;
      rxs       <= rx_meta;
      rxs_d     <= rxs;
      overrun_o <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
      break_o   <= 1'b0;
`endif

      if (start) begin
        presc <= baud_div_i;
        tcnt  <= '0;
      end else if (tick) begin
        presc <= baud_div_i;
        tcnt  <= (tcnt == T_LAST) ? '0 : tcnt + 1'b1;
      end else begin
        presc <= presc - 1'b1;
      end

      if (tick && (tcnt == T_S0)) s0 <= rxs;
      if (tick && (tcnt == T_S1)) s1 <= rxs;

      if (start) begin
        nbits   <= nbits_clamp;
        pmode   <= parity_mode_i;
        stop2_l <= stop2_i;
        bit_cnt <= '0;
        shreg   <= '0;
        perr    <= 1'b0;
        ferr    <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
        allz    <= 1'b1;
        brk     <= 1'b0;
`endif
      end

      if (vote_tick) begin
        case (state)
          RDT: begin
            shreg   <= shreg | (DATA_W'(vote) << bit_cnt);
            bit_cnt <= bit_cnt + 1'b1;
`ifdef UART_RX_BREAK_DET_EN
            if (vote) allz <= 1'b0;
`endif
          end
          RPARB: begin
            // pmode[1] is set only for odd parity, which expects an XOR of 1
            perr <= (^shreg) ^ vote ^ pmode[1];
`ifdef UART_RX_BREAK_DET_EN
            if (vote) allz <= 1'b0;
`endif
          end
          RSTB1: begin
            if (!vote) ferr <= 1'b1;
`ifdef UART_RX_BREAK_DET_EN
            if (allz && !vote) begin
              brk     <= 1'b1;
              break_o <= 1'b1;
            end
`endif
          end
          RSTB2: if (!vote) ferr <= 1'b1;
          default: ;
        endcase
      end

      if (wend_wr) begin
        if (!m_valid_o || m_ready_i) begin
          m_data_o     <= shreg;
          parity_err_o <= perr;
          frame_err_o  <= ferr;
          m_valid_o    <= 1'b1;
        end else begin
          overrun_o <= 1'b1;
        end
      end else if (m_valid_o && m_ready_i) begin
        m_valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_param.sv
// Randomised and directed bench for uart_rx_param against a frame-level reference model.
module tb_uart_rx_param;

  localparam int BIT = 32;
`ifdef UART_RX_BREAK_DET_EN
  localparam bit BRK_EN = 1'b1;
`else
  localparam bit BRK_EN = 1'b0;
`endif

  logic        clk, rst, rx_i;
  logic [15:0] baud_div_i;
  logic [3:0]  data_bits_i;
  logic [1:0]  parity_mode_i;
  logic        stop2_i, m_ready_i;
  logic [7:0]  m_data_o;
  logic        m_valid_o, parity_err_o, frame_err_o, overrun_o, busy_o, break_o;

  uart_rx_param #(.DATA_W(8), .RATIO(8), .DIV_W(16)) dut (
    .clk(clk), .rst(rst), .rx_i(rx_i), .baud_div_i(baud_div_i),
    .data_bits_i(data_bits_i), .parity_mode_i(parity_mode_i), .stop2_i(stop2_i),
    .m_data_o(m_data_o), .m_valid_o(m_valid_o), .m_ready_i(m_ready_i),
    .parity_err_o(parity_err_o), .frame_err_o(frame_err_o), .overrun_o(overrun_o),
    .busy_o(busy_o), .break_o(break_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic [7:0] d; logic pe; logic fe; } exp_t;
  exp_t exp_q[$];
  int checks = 0, errors = 0;
  int ovr_cnt = 0, brk_cnt = 0, vld_cnt = 0, exp_brk = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (overrun_o) ovr_cnt++;
      if (break_o) brk_cnt++;
      if (m_valid_o && m_ready_i) begin
        vld_cnt++;
        if (exp_q.size() == 0) begin
          chk("unexpected_word", {24'h0, m_data_o}, 32'hffff_ffff);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("data", {24'h0, m_data_o}, {24'h0, e.d});
          chk("parity_err", {31'h0, parity_err_o}, {31'h0, e.pe});
          chk("frame_err", {31'h0, frame_err_o}, {31'h0, e.fe});
        end
      end
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    rx_i = 1'b1;
    wait_clk(n);
  endtask

  // Drives one frame and records what the receiver should report for it.
  task automatic send_frame(input logic [7:0] d, input logic [3:0] nb_raw, input logic [1:0] pm,
                            input logic s2, input logic par_flip, input logic st1,
                            input logic st2, input logic push);
    int nb;
    logic [7:0] mask, dm;
    logic pen, par_bit, is_brk;
    exp_t e;
    nb = (nb_raw < 5) ? 5 : ((nb_raw > 8) ? 8 : int'(nb_raw));
    mask = 8'hff >> (8 - nb);
    dm = d & mask;
    pen = (pm == 2'b01) || (pm == 2'b10);
    par_bit = ((pm == 2'b10) ? ~(^dm) : (^dm)) ^ par_flip;
    is_brk = (dm == 8'h00) && (!pen || !par_bit) && !st1;
    if (BRK_EN && is_brk) begin
      exp_brk++;
    end else if (push) begin
      e.d = dm;
      e.pe = pen && par_flip;
      e.fe = !st1 || (s2 && !st2);
      exp_q.push_back(e);
    end
    data_bits_i = nb_raw;
    parity_mode_i = pm;
    stop2_i = s2;
    rx_i = 1'b0;
    wait_clk(BIT);
    // Configuration must be latched at start; disturb it mid-frame.
    data_bits_i = 4'($urandom);
    parity_mode_i = 2'($urandom);
    stop2_i = 1'($urandom);
    for (int i = 0; i < nb; i++) begin
      rx_i = dm[i];
      wait_clk(BIT);
    end
    if (pen) begin
      rx_i = par_bit;
      wait_clk(BIT);
    end
    rx_i = st1;
    wait_clk(BIT);
    if (s2) begin
      rx_i = st2;
      wait_clk(BIT);
    end
  endtask

  task automatic frame(input logic [7:0] d, input logic [3:0] nb, input logic [1:0] pm,
                       input logic s2, input logic pf, input logic st1, input logic st2,
                       input logic push);
    send_frame(d, nb, pm, s2, pf, st1, st2, push);
    idle(40);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"}, {31'h0, m_valid_o}, 32'h0);
    chk({tag, "_data"}, {24'h0, m_data_o}, 32'h0);
    chk({tag, "_flags"}, {29'h0, parity_err_o, frame_err_o, overrun_o}, 32'h0);
    chk({tag, "_busy_brk"}, {30'h0, busy_o, break_o}, 32'h0);
  endtask

  initial begin
    int v0, o0;
    rst = 1'b1; rx_i = 1'b1; baud_div_i = 16'd3; data_bits_i = 4'd8;
    parity_mode_i = 2'b00; stop2_i = 1'b0; m_ready_i = 1'b1;
    wait_clk(3);
    chk_all_zero("reset");
    rst = 1'b0;
    idle(20);

    // 8N1 0xA5
    v0 = vld_cnt;
    frame(8'hA5, 4'd8, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    chk("a5_one_pulse", vld_cnt - v0, 1);
    chk("a5_busy_low", {31'h0, busy_o}, 32'h0);

    // 7E2 0x3C with bad then good parity
    frame(8'h3C, 4'd7, 2'b01, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    frame(8'h3C, 4'd7, 2'b01, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);

    // false start glitch, then 0x55
    v0 = vld_cnt;
    rx_i = 1'b0;
    wait_clk(10);
    idle(60);
    chk("glitch_no_word", vld_cnt - v0, 0);
    chk("glitch_idle", {31'h0, busy_o}, 32'h0);
    frame(8'h55, 4'd8, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    chk("drain_basic", exp_q.size(), 0);

    // overrun
    m_ready_i = 1'b0;
    o0 = ovr_cnt;
    frame(8'h11, 4'd8, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    frame(8'h22, 4'd8, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("ovr_hold_valid", {31'h0, m_valid_o}, 32'h1);
    chk("ovr_hold_data", {24'h0, m_data_o}, 32'h11);
    chk("ovr_pulses", ovr_cnt - o0, 1);
    m_ready_i = 1'b1;
    wait_clk(2);
    chk("ovr_valid_clear", {31'h0, m_valid_o}, 32'h0);
    chk("drain_ovr", exp_q.size(), 0);

    // frame error, then all-zero with low stop (break)
    frame(8'h81, 4'd8, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    v0 = vld_cnt;
    send_frame(8'h00, 4'd8, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    wait_clk(64);
    chk("brk_busy_hold", {31'h0, busy_o}, {31'h0, BRK_EN});
    idle(40);
    chk("brk_busy_after", {31'h0, busy_o}, 32'h0);
    chk("brk_pulses", brk_cnt, exp_brk);
    chk("brk_words", vld_cnt - v0, BRK_EN ? 0 : 1);
    chk("drain_brk", exp_q.size(), 0);

    // reset mid-frame with a word pending
    m_ready_i = 1'b0;
    frame(8'h77, 4'd8, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("pre_rst_valid", {31'h0, m_valid_o}, 32'h1);
    rx_i = 1'b0; wait_clk(BIT);
    rx_i = 1'b1; wait_clk(BIT);
    rx_i = 1'b0; wait_clk(BIT);
    rx_i = 1'b1; wait_clk(BIT);
    wait_clk(16);
    rst = 1'b1;
    wait_clk(1);
    chk_all_zero("midrst");
    rst = 1'b0;
    m_ready_i = 1'b1;
    v0 = vld_cnt;
    idle(200);
    chk("midrst_no_word", vld_cnt - v0, 0);
    frame(8'hC3, 4'd8, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    chk("drain_rst", exp_q.size(), 0);

    // randomised frames
    for (int n = 0; n < 20; n++) begin
      frame(8'($urandom), 4'($urandom), 2'($urandom), 1'($urandom),
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) != 0),
            ($urandom_range(0, 5) != 0), 1'b1);
    end
    chk("drain_rand", exp_q.size(), 0);
    chk("brk_total", brk_cnt, exp_brk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
